cla_mp_seq: RTL and testbench
=============================

# cla_mp_seq

Multi-precision add/subtract sequencer built around the existing `cla_8bit` adder. It accepts two NBYTES-wide operands through a valid/ready request handshake and feeds them through a single `cla_8bit` one byte per cycle, LSB first. The carry is chained through a register between cycles. The full-width result and flags are returned on a valid/ready response handshake. It is the arithmetic engine for wide counters and checksum paths that cannot afford NBYTES parallel adders.

## Interface
- `NBYTES`, 4: operand width in bytes; legal range 2..16; W = 8*NBYTES.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_sub` in 1: 1 = a − b, 0 = a + b + cin.
- `req_cin` in 1: carry-in for add; ignored when `req_sub`=1.
- `req_a` in W: operand A.
- `req_b` in W: operand B.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_sum` out W: result.
- `rsp_cout` out 1: final carry out; for subtract, 1 = no borrow.
- `rsp_ovf` out 1: signed overflow of the W-bit operation.
- `rsp_zero` out 1: `rsp_sum` == 0.
- `busy` out 1: high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `req_ready`=1.
  - When `req_valid`=1, latch `req_a`, `req_b` (inverted if `req_sub`) and `req_sub`.
  - Set carry reg = `req_sub` ? 1 : `req_cin` and idx = 0, then go to RUN.
- **RUN**
  - `cla_8bit` inputs: a = A[idx], b = B'[idx], cin = carry reg.
  - `sum` is written to result byte idx; carry reg <= `cout`; idx <= idx+1.
  - At idx == NBYTES−1, also capture `rsp_cout` = `cout`.
  - `rsp_ovf` = (A[W−1] == B'[W−1]) && (sum[7] != A[W−1]), evaluated on the top byte.
  - Go to DONE.
- **DONE**
  - `rsp_valid`=1.
  - `rsp_sum`, `rsp_cout`, `rsp_ovf` and `rsp_zero` hold stable until `rsp_valid && rsp_ready`, then go to IDLE.
- `req_ready`=0 in RUN and DONE. Requests presented there are not accepted and must be held by the requester.
- Byte writes are direct indexed. The result register is not cleared on accept; every byte is overwritten before DONE.
- `rsp_zero` is computed combinationally from the result register. It is valid only while `rsp_valid`=1.
- Idx width = clog2(NBYTES). Idx wraps only by leaving RUN, never by arithmetic overflow.

## Timing
- **Reset** (asynchronous, immediate):
  - state = IDLE, idx = 0, carry = 0.
  - Result register = 0, `rsp_cout` = `rsp_ovf` = 0.
  - Outputs: `rsp_valid`=0, `busy`=0, `req_ready`=1 once `rst` deasserts.
- Reset mid-RUN or mid-DONE aborts the operation. No response is ever issued for it.
- **Latency**
  - Request accepted at edge E.
  - `rsp_valid` rises after edge E+NBYTES, i.e. NBYTES RUN cycles.
  - With `rsp_ready` held at 1, the response is consumed at edge E+NBYTES+1.
  - The next request is accepted no earlier than edge E+NBYTES+2.
  - Throughput: one operation per NBYTES+2 cycles.
- `rsp_ready` asserted before `rsp_valid` has no effect.
- `rsp_ready` and a new `req_valid` in the same DONE cycle: the response is consumed. The request is accepted on the following cycle, from IDLE.
- `cla_8bit` is purely combinational. The critical path is the 8-bit carry-lookahead plus the idx mux, one byte per cycle.

## Structure
- `cla_pkg` holds:
  - the FSM state enum (IDLE/RUN/DONE);
  - localparam `BYTE_W` = 8;
  - the default NBYTES.
- One sub-module: the existing `cla_8bit`, instantiated once.
- Operand/result storage, idx counter, carry reg and FSM live in `cla_mp_seq`.

## Test plan
All scenarios run with NBYTES=4 and `rsp_ready`=1 unless stated.
- **Full carry ripple:** A=0xFFFFFFFF, B=0x00000001, add, cin=0 -> sum 0x00000000, cout 1, zero 1, ovf 0. `rsp_valid` rises exactly 4 cycles after accept.
- **Inter-byte carry with cin:** A=0x00FF00FF, B=0x00010001, cin=1 -> sum 0x01000101, cout 0, zero 0.
- **Signed overflow:** A=0x7FFFFFFF + B=0x00000001 -> sum 0x80000000, ovf 1, cout 0.
- **Subtract with borrow:** A=5, B=7, sub=1, cin=1 (ignored) -> sum 0xFFFFFFFE, cout 0, ovf 0.
- **Subtract, no borrow:** A=7, B=5, sub=1 -> sum 0x00000002, cout 1.
- **Backpressure:** hold `rsp_ready`=0 for 5 cycles after `rsp_valid`.
  - Outputs stay stable and `req_ready` stays 0 throughout.
  - A `req_valid` held during DONE is accepted exactly one cycle after the response handshake.
- **Reset mid-RUN:** assert `rst` at idx=2.
  - All outputs reach their reset values immediately and `rsp_valid` never pulses.
  - A following add of 1+1 returns 0x00000002.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and constants for the multi-precision add/subtract sequencer.
package cla_pkg;

    localparam int BYTE_W     = 8;
    localparam int NBYTES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_8bit.sv
// 8-bit carry-lookahead adder, purely combinational.
module cla_8bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [8:0] w_c;

    assign w_g    = i_a & i_b;
    assign w_p    = i_a ^ i_b;
    assign w_c[0] = i_cin;

    // Each carry is a flat sum of products over generate/propagate terms.
    for (genvar i = 0; i < 8; i++) begin : g_carry
        logic [i+1:0] w_terms;
        assign w_terms[0] = (&w_p[i:0]) & i_cin;
        for (genvar j = 0; j <= i; j++) begin : g_term
            if (j == i) begin : g_gen
                assign w_terms[j+1] = w_g[j];
            end else begin : g_prop
                assign w_terms[j+1] = w_g[j] & (&w_p[i:j+1]);
            end
        end
        assign w_c[i+1] = |w_terms;
    end

    assign o_sum  = w_p ^ w_c[7:0];
    assign o_cout = w_c[8];

endmodule

// File: rtl/cla_mp_seq.sv
// Multi-precision add/subtract: one cla_8bit fed one byte per cycle, LSB first,
// with the carry chained through a register between cycles.
//
// state   | meaning
// IDLE    | ready for a request
// RUN     | processing byte r_idx
// DONE    | result presented, waiting for rsp_ready
module cla_mp_seq
    import cla_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_sub,
    input  logic                     req_cin,
    input  logic [BYTE_W*NBYTES-1:0] req_a,
    input  logic [BYTE_W*NBYTES-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [BYTE_W*NBYTES-1:0] rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf,
    output logic                     rsp_zero,
    output logic                     busy
);

    localparam int W  = BYTE_W * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic            r_cout;
    logic            r_ovf;

    logic [BYTE_W-1:0] w_a_byte;
    logic [BYTE_W-1:0] w_b_byte;
    logic [BYTE_W-1:0] w_sum;
    logic              w_cout;

    assign w_a_byte = r_a[r_idx*BYTE_W +: BYTE_W];
    assign w_b_byte = r_b[r_idx*BYTE_W +: BYTE_W];

    cla_8bit u_cla (
        .i_a    (w_a_byte),
        .i_b    (w_b_byte),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        // Subtract is a + ~b + 1, so B is stored pre-inverted.
                        r_a     <= req_a;
                        r_b     <= req_sub ? ~req_b : req_b;
                        r_carry <= req_sub | req_cin;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[r_idx*BYTE_W +: BYTE_W] <= w_sum;
                    r_carry <= w_cout;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_cout;
                        r_ovf   <= (r_a[W-1] == r_b[W-1]) && (w_sum[BYTE_W-1] != r_a[W-1]);
                        r_idx   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign rsp_sum   = r_sum;
    assign rsp_cout  = r_cout;
    assign rsp_ovf   = r_ovf;
    assign rsp_zero  = (r_sum == '0);

endmodule

// File: tb/tb_cla_mp_seq.sv
// Scoreboard bench for cla_mp_seq with NBYTES=4 and hand-computed vectors.
module tb_cla_mp_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_sub;
    logic        req_cin;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_ovf;
    logic        rsp_zero;
    logic        busy;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_pass  = 0;
    int   n_total = 0;

    cla_mp_seq #(.NBYTES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sub   (req_sub),
        .req_cin   (req_cin),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, expv);
    endtask

    // Monitor: pops the oldest expectation on every response handshake.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rsp: got sum %h with no pending request", rsp_sum);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rsp_sum",  rsp_sum,          mon_e.sum);
                chk("rsp_cout", 32'(rsp_cout),    32'(mon_e.cout));
                chk("rsp_ovf",  32'(rsp_ovf),     32'(mon_e.ovf));
                chk("rsp_zero", 32'(rsp_zero),    32'(mon_e.zero));
            end
        end
    end

    // Drive a request and return just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        input logic cin, input bit push, input logic [31:0] es,
                        input logic ec, input logic eo);
        int n;
        @(posedge clk); #1;
        req_a = a; req_b = b; req_sub = sub; req_cin = cin; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (push) exp_q.push_back('{es, ec, eo, (es == 32'd0)});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        int hi_cnt;
        rst = 1'b1; req_valid = 1'b0; req_sub = 1'b0; req_cin = 1'b0;
        req_a = '0; req_b = '0; rsp_ready = 1'b1;
        #12;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_sum",       rsp_sum,        32'd0);
        chk("rst_cout_ovf",  32'({rsp_cout, rsp_ovf}), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);

        // Full carry ripple, with exact latency check.
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("lat_low", 32'(rsp_valid), 32'd0);
        end
        @(negedge clk);
        chk("lat_rise", 32'(rsp_valid), 32'd1);
        wait_idle();

        send(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b1, 1'b1, 32'h0100_0101, 1'b0, 1'b0);
        wait_idle();
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
        wait_idle();
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        wait_idle();
        send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0);
        wait_idle();
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        wait_idle();

        // Backpressure: result held 5 cycles while a new request waits.
        @(posedge clk); #1; rsp_ready = 1'b0;
        send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 32'h0000_0003, 1'b0, 1'b0);
        hi_cnt = 0;
        @(negedge clk);
        while (!rsp_valid && hi_cnt < 20) begin
            @(negedge clk);
            hi_cnt++;
        end
        chk("bp_valid_rise", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        req_a = 32'h0000_0010; req_b = 32'h0000_0020; req_sub = 1'b0; req_cin = 1'b0;
        req_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_hold", {rsp_sum[28:0], rsp_valid, req_ready, rsp_cout | rsp_ovf},
                {29'h3, 1'b1, 1'b0, 1'b0});
        end
        @(posedge clk); #1; rsp_ready = 1'b1;
        exp_q.push_back('{32'h0000_0030, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_idle_after_hs", 32'({req_ready, busy}), 32'b10);
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk);
        chk("bp_accept_next", 32'({req_ready, busy}), 32'b01);
        wait_idle();

        // Reset in the middle of RUN aborts without a response.
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy",      32'(busy),      32'd0);
        chk("abort_sum",       rsp_sum,        32'd0);
        chk("abort_cout_ovf",  32'({rsp_cout, rsp_ovf}), 32'd0);
        @(posedge clk); #1; rst = 1'b0;
        hi_cnt = 0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            if (rsp_valid) hi_cnt++;
        end
        chk("abort_no_rsp", 32'(hi_cnt), 32'd0);
        send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 1'b1, 32'h0000_0002, 1'b0, 1'b0);
        wait_idle();

        @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
